alu_input_ctrl: RTL
===================

// Module: alu_input_ctrl
// PURPOSE
//  Board-level sequencer for the combinational ALU: debounces three push-buttons and latches
//  operand A, operand B and the opcode from shared slide switches, one step at a time.
//  It then runs one EXEC cycle and registers the ALU result for the LEDs.
//  Sits between board I/O (switches/buttons/LEDs) and the alu instance.
// PARAMETERS
//  NB_DATA    8        operand/result width; also switch width
//  NB_OP      6        opcode width; NB_OP <= NB_DATA
//  DB_CYCLES  1000000  stable cycles required to accept a button level change; >= 2
// PORTS
//  i_clk          in   1        system clock, all logic on rising edge
//  i_rst_n        in   1        synchronous reset, active-low
//  i_sw           in   NB_DATA  slide switches, asynchronous
//  i_btn_a        in   1        load-A button, asynchronous, active-high
//  i_btn_b        in   1        load-B button, asynchronous, active-high
//  i_btn_op       in   1        load-opcode button, asynchronous, active-high
//  i_alu_result   in   NB_DATA  result from the ALU (combinational from o_data_a/b, o_operation)
//  o_data_a       out  NB_DATA  registered operand A to the ALU, signed
//  o_data_b       out  NB_DATA  registered operand B to the ALU, signed
//  o_operation    out  NB_OP    registered opcode to the ALU
//  o_result       out  NB_DATA  registered result to the LEDs
//  o_result_valid out  1        high in SHOW: o_result is current
//  o_state        out  2        FSM state for debug LEDs
//  o_op_error     out  1        illegal opcode flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (i_rst_n=0 at an edge): all outputs 0, state IDLE, sync FFs/debounce levels/counters 0.
//   Applies in any state, mid-sequence included. A button held through reset re-debounces
//   and produces one pulse afterwards.
//  Per button: 2-FF synchronizer, then counter. Counter +1 each cycle sync != debounced level,
//   cleared when equal. Debounced level toggles when counter would reach DB_CYCLES.
//   Counter saturation must not wrap.
//  Press pulse = debounced & ~debounced_q, exactly 1 cycle per press; release gives none.
//   Raw high first sampled at edge N -> pulse high in cycle after edge N+DB_CYCLES+1 ->
//   register load at edge N+DB_CYCLES+2.
//  Glitch shorter than DB_CYCLES cycles -> no pulse.
//  FSM (o_state encoding): IDLE=0, WAIT_B=1, WAIT_OP=2, EXEC/SHOW=3; internal EXEC != SHOW.
//   IDLE    : pulse_a -> o_data_a<=i_sw, go WAIT_B
//   WAIT_B  : pulse_b -> o_data_b<=i_sw, go WAIT_OP
//   WAIT_OP : pulse_op -> o_operation<=i_sw[NB_OP-1:0], go EXEC
//   EXEC    : 1 cycle; o_result<=i_alu_result, o_result_valid<=1, go SHOW
//   SHOW    : hold result; pulse_a -> o_data_a<=i_sw, o_result_valid<=0, go WAIT_B;
//             o_result retains old value until next EXEC
//  Pulses not matching the current state are ignored and dropped, never queued.
//  Simultaneous pulses: only the one relevant to the state acts.
//  Operands and opcode hold between loads; i_sw changes outside load edges have no effect.
//  No arithmetic in this block; widths pass through unmodified (signed reinterpretation in ALU).
// CONFIGURATION
//  ALU_OPCODE_CHECK_EN defined: in WAIT_OP, pulse_op with i_sw[NB_OP-1:0] not in
//   {100000,100010,100100,100101,100110,100111,000011,000010} does not load o_operation.
//   FSM stays WAIT_OP and o_op_error<=1 (sticky).
//   Cleared by the next legal pulse_op (same edge as the load) or by reset.
//  ALU_OPCODE_CHECK_EN undefined: any opcode accepted; o_op_error tied 0.
// TESTING (bench DB_CYCLES=4)
//  reset held 3 cycles mid-WAIT_OP -> all outputs 0, o_state=0; released -> IDLE, no spurious load
//  sw=0x05 pulse A, sw=0xFD pulse B, sw=0x20 pulse OP (ADD) -> o_data_a=5, o_data_b=-3;
//   o_result=0x02, valid=1 one cycle after opcode load
//  btn_a high 3 cycles then low -> no pulse, state unchanged; held 6 cycles -> one load at N+DB_CYCLES+2
//  in WAIT_B press A+B together -> only o_data_b loads, o_data_a unchanged, go WAIT_OP
//  in SHOW press A with sw=0x80 -> valid=0, o_data_a=0x80, o_result holds, state WAIT_B
//  [ALU_OPCODE_CHECK_EN] opcode 0x3F -> o_op_error=1, stays WAIT_OP; then 0x22 -> loads SUB, error=0

Source files
------------

// File: rtl/alu_input_ctrl_if.sv
// Board/ALU signal bundle for alu_input_ctrl: switches, buttons, ALU operands and LED result.
// The slave modport is the sequencer's view; master is the board/ALU side.
interface alu_input_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_sw;
  logic               i_btn_a;
  logic               i_btn_b;
  logic               i_btn_op;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_operation;
  logic [NB_DATA-1:0] o_result;
  logic               o_result_valid;
  logic [1:0]         o_state;
  logic               o_op_error;

  modport master (
    output i_sw, i_btn_a, i_btn_b, i_btn_op, i_alu_result,
    input  o_data_a, o_data_b, o_operation, o_result, o_result_valid, o_state, o_op_error
  );

  modport slave (
    input  i_sw, i_btn_a, i_btn_b, i_btn_op, i_alu_result,
    output o_data_a, o_data_b, o_operation, o_result, o_result_valid, o_state, o_op_error
  );
endinterface

// File: rtl/alu_input_ctrl.sv
// Debounces the A/B/OP buttons, latches operands and opcode from the switches, runs one EXEC
// cycle and holds the ALU result for the LEDs. Optional macro ALU_OPCODE_CHECK_EN rejects illegal opcodes.
module alu_input_ctrl #(
  parameter int NB_DATA   = 8,
  parameter int NB_OP     = 6,
  parameter int DB_CYCLES = 1000000
) (
  input logic              i_clk,
  input logic              i_rst_n,
  alu_input_ctrl_if.slave  bus
);
  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  logic [2:0] btn_raw;
  logic [2:0] pulse;

  assign btn_raw = {bus.i_btn_op, bus.i_btn_b, bus.i_btn_a};

  // Bit 0 = A, bit 1 = B, bit 2 = OP. The counter never exceeds DB_CYCLES-1, so it cannot wrap.
  for (genvar gi = 0; gi < 3; gi++) begin : g_db
    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_q_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        sync1_reg   <= 1'b0;
        sync2_reg   <= 1'b0;
        level_reg   <= 1'b0;
        level_q_reg <= 1'b0;
        cnt_reg     <= '0;
      end else begin
        sync1_reg   <= btn_raw[gi];
        sync2_reg   <= sync1_reg;
        level_q_reg <= level_reg;
        if (sync2_reg == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
          level_reg <= ~level_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign pulse[gi] = level_reg & ~level_q_reg;
  end

`ifdef ALU_OPCODE_CHECK_EN
  function automatic logic op_legal(input logic [NB_OP-1:0] op);
    case (op)
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100), NB_OP'(6'b100101),
      NB_OP'(6'b100110), NB_OP'(6'b100111), NB_OP'(6'b000011), NB_OP'(6'b000010):
        op_legal = 1'b1;
      default:
        op_legal = 1'b0;
    endcase
  endfunction

  logic op_error_reg;
  assign bus.o_op_error = op_error_reg;
`else
  assign bus.o_op_error = 1'b0;
`endif

  state_t             state_reg;
  logic [1:0]         state_out_reg;
  logic [NB_DATA-1:0] data_a_reg;
  logic [NB_DATA-1:0] data_b_reg;
  logic [NB_OP-1:0]   operation_reg;
  logic [NB_DATA-1:0] result_reg;
  logic               result_valid_reg;

  // EXEC and SHOW share debug code 3; pulses irrelevant to the current state fall through unused.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg        <= IDLE;
      state_out_reg    <= 2'd0;
      data_a_reg       <= '0;
      data_b_reg       <= '0;
      operation_reg    <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
`ifdef ALU_OPCODE_CHECK_EN
      op_error_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, SHOW: begin
          if (pulse[0]) begin
            data_a_reg       <= bus.i_sw;
            result_valid_reg <= 1'b0;
            state_reg        <= WAIT_B;
            state_out_reg    <= 2'd1;
          end
        end
        WAIT_B: begin
          if (pulse[1]) begin
            data_b_reg    <= bus.i_sw;
            state_reg     <= WAIT_OP;
            state_out_reg <= 2'd2;
          end
        end
        WAIT_OP: begin
          if (pulse[2]) begin
`ifdef ALU_OPCODE_CHECK_EN
            if (op_legal(bus.i_sw[NB_OP-1:0])) begin
              operation_reg <= bus.i_sw[NB_OP-1:0];
              op_error_reg  <= 1'b0;
              state_reg     <= EXEC;
              state_out_reg <= 2'd3;
            end else begin
              op_error_reg  <= 1'b1;
            end
`else
            operation_reg <= bus.i_sw[NB_OP-1:0];
            state_reg     <= EXEC;
            state_out_reg <= 2'd3;
`endif
          end
        end
        EXEC: begin
          result_reg       <= bus.i_alu_result;
          result_valid_reg <= 1'b1;
          state_reg        <= SHOW;
          state_out_reg    <= 2'd3;
        end
        default: begin
          state_reg     <= IDLE;
          state_out_reg <= 2'd0;
        end
      endcase
    end
  end

  assign bus.o_data_a       = data_a_reg;
  assign bus.o_data_b       = data_b_reg;
  assign bus.o_operation    = operation_reg;
  assign bus.o_result       = result_reg;
  assign bus.o_result_valid = result_valid_reg;
  assign bus.o_state        = state_out_reg;
endmodule
